uart_hex_rx_parser: RTL and testbench
=====================================

# uart_hex_rx_parser

Byte-stream parser on the UART receive path. Sits directly downstream of the receive interface (RIF): consumes received bytes, interprets them as ASCII hexadecimal digits, and on a line terminator commits a 32-bit value for the register read mux (address 0x3 slot). It replaces ad-hoc shift-in of raw bytes with a framed, error-checked number entry.

## Interface
- MAX_DIGITS, 8, maximum hex digits per value (1..8); more digits before a terminator is an overflow error.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_vld  in  1  RIF byte-valid; may stay high for several clk cycles per byte.
- rx_byte  in  8  RIF received byte; stable while rx_vld is high.
- value  out  32  last committed value, zero-extended; holds until next commit.
- val_vld  out  1  one-cycle pulse when value updates.
- err  out  1  one-cycle pulse when an errored line is discarded.
- busy  out  1  high while a line is in progress (state ACCUM or DISCARD).
- ndig  out  4  digits currently accumulated (0..MAX_DIGITS).

## Operation
- Byte acceptance: rx_vld is rising-edge detected (registered rx_vld_d). A byte is accepted only in the cycle rx_vld=1 and rx_vld_d=0; rx_byte is sampled in that cycle. Level held high = one byte.
- Classes: digit = 0x30-0x39, 0x41-0x46, 0x61-0x66 (nibble 0-9, A-F, a-f); term = 0x0D or 0x0A; bksp = 0x08 or 0x7F; everything else = invalid.
- States: IDLE, ACCUM, DISCARD.
- IDLE: digit -> acc={28'b0,nibble}, ndig=1, ACCUM. term -> ignored (so CR LF commits once). bksp -> ignored. invalid -> DISCARD.
- ACCUM: digit with ndig<MAX_DIGITS -> acc={acc[27:0],nibble}, ndig+1. digit with ndig=MAX_DIGITS -> DISCARD (overflow). term -> value<=acc, val_vld pulse, acc=0, ndig=0, IDLE. invalid -> DISCARD. bksp: see Configuration.
- DISCARD: all bytes except term ignored; term -> err pulse, acc=0, ndig=0, IDLE. No val_vld.
- value never changes except on commit; err and val_vld never both high.

## Timing
- Reset: state=IDLE, acc=0, ndig=0, value=0, val_vld=0, err=0, busy=0, rx_vld_d=0.
- Accepted byte updates state/acc/ndig at the next rising edge (1-cycle latency).
- val_vld and value update on the same edge that consumes the terminator; val_vld high exactly one cycle.
- Minimum byte spacing: rx_vld low for >=1 cycle between bytes; every 2 cycles sustainable.
- rx_vld high out of reset: rx_vld_d resets to 0, so a byte valid at reset release is accepted once.
- Reset mid-line: partial line lost, value returns to 0, no pulses.

## Configuration
- HEX_RX_BACKSPACE_EN defined: bksp in ACCUM -> acc=acc>>4, ndig-1; if ndig reaches 0 -> IDLE (busy drops). bksp in IDLE/DISCARD ignored.
- HEX_RX_BACKSPACE_EN undefined: bksp is classed invalid in every state (IDLE/ACCUM -> DISCARD).

## Test plan
- Bytes "1A2b3C4d",0x0D (each rx_vld 3 cycles high, 2 low) -> one val_vld pulse, value=0x1A2B3C4D, ndig back to 0, err never high.
- "7F",0x0D,0x0A -> single val_vld, value=0x0000007F; second terminator produces nothing.
- "123456789",0x0D (MAX_DIGITS=8) -> no val_vld, one err pulse on CR, value keeps previous 0x0000007F.
- "12G4",0x0A -> err pulse, no commit; following "5",0x0D -> value=0x00000005.
- With HEX_RX_BACKSPACE_EN: "ABC",0x08,"D",0x0D -> value=0x00000ABD; without macro same stream -> err pulse, value unchanged.
- Assert rst during "DEAD" (before CR) -> value=0, busy=0, ndig=0; then "1",0x0D -> value=0x00000001.

Source files
------------

// File: rtl/uart_hex_rx_parser_if.sv
// Byte stream from the UART receive interface into the hex parser, plus the parser's
// committed value and status back out.
interface uart_hex_rx_parser_if;
  logic        rx_vld;
  logic [7:0]  rx_byte;
  logic [31:0] value;
  logic        val_vld;
  logic        err;
  logic        busy;
  logic [3:0]  ndig;

  modport master (
    output rx_vld, rx_byte,
    input  value, val_vld, err, busy, ndig
  );

  modport slave (
    input  rx_vld, rx_byte,
    output value, val_vld, err, busy, ndig
  );
endinterface

// File: rtl/uart_hex_rx_parser.sv
// ASCII hex number parser: accumulates hex digits and commits a 32-bit value on CR/LF.
// Define HEX_RX_BACKSPACE_EN to let BS/DEL remove the last digit while accumulating.
module uart_hex_rx_parser #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input logic                 clk,
  input logic                 rst,
  uart_hex_rx_parser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDiscard} state_e;

  localparam logic [3:0] MaxNdig = 4'(MAX_DIGITS);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  ndig_q, ndig_d;
  logic [31:0] value_q, value_d;
  logic        val_vld_q, val_vld_d;
  logic        err_q, err_d;
  logic        rx_vld_q;

  logic        accept;
  logic        is_digit;
  logic        is_term;
  logic        bksp_ok;
  logic        is_invalid;
  logic [3:0]  nibble;

  // A byte is taken only on the rising edge of rx_vld, however long it stays high.
  assign accept = bus.rx_vld & ~rx_vld_q;

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = bus.rx_byte[3:0];
    end else if ((bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h46) ||
                 (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = bus.rx_byte[3:0] + 4'd9;
    end
  end

  assign is_term = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);

`ifdef HEX_RX_BACKSPACE_EN
  assign bksp_ok = (bus.rx_byte == 8'h08) || (bus.rx_byte == 8'h7F);
`else
  // Without backspace support BS/DEL fall through to the invalid class.
  assign bksp_ok = 1'b0;
`endif

  assign is_invalid = ~is_digit & ~is_term & ~bksp_ok;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ndig_d    = ndig_q;
    value_d   = value_q;
    val_vld_d = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (is_digit) begin
            acc_d   = {28'b0, nibble};
            ndig_d  = 4'd1;
            state_d = StAccum;
          end else if (is_invalid) begin
            state_d = StDiscard;
          end
        end
        StAccum: begin
          if (is_digit) begin
            if (ndig_q == MaxNdig) begin
              state_d = StDiscard;
            end else begin
              acc_d  = {acc_q[27:0], nibble};
              ndig_d = ndig_q + 4'd1;
            end
          end else if (is_term) begin
            value_d   = acc_q;
            val_vld_d = 1'b1;
            acc_d     = '0;
            ndig_d    = '0;
            state_d   = StIdle;
          end else if (bksp_ok) begin
            acc_d  = acc_q >> 4;
            ndig_d = ndig_q - 4'd1;
            if (ndig_q == 4'd1) state_d = StIdle;
          end else begin
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (is_term) begin
            err_d   = 1'b1;
            acc_d   = '0;
            ndig_d  = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      ndig_q    <= '0;
      value_q   <= '0;
      val_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ndig_q    <= ndig_d;
      value_q   <= value_d;
      val_vld_q <= val_vld_d;
      err_q     <= err_d;
      rx_vld_q  <= bus.rx_vld;
    end
  end

  assign bus.value   = value_q;
  assign bus.val_vld = val_vld_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.ndig    = ndig_q;

endmodule

// File: tb/tb_uart_hex_rx_parser.sv
// Scoreboard bench for uart_hex_rx_parser: expected commits/errors are queued as lines are
// sent and matched against val_vld/err pulses.
module tb_uart_hex_rx_parser;

  typedef struct {
    logic        is_err;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  uart_hex_rx_parser_if bus ();

  uart_hex_rx_parser #(.MAX_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_vld  = 1'b1;
    bus.rx_byte = b;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_vld = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_exp(input logic is_err, input logic [31:0] v);
    exp_t e;
    e.is_err = is_err;
    e.value  = v;
    exp_q.push_back(e);
  endtask

  // Pulse monitor: every val_vld/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.val_vld || bus.err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'b0, bus.err, bus.val_vld}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("pulse_kind", {30'b0, bus.err, bus.val_vld},
                 e.is_err ? 32'd2 : 32'd1);
        if (!e.is_err) check_eq("commit_value", bus.value, e.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    string s1;
    logic [31:0] last_val;
    bus.rx_vld  = 1'b0;
    bus.rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_value", bus.value, 32'd0);
    check_eq("rst_val_vld", {31'b0, bus.val_vld}, 32'd0);
    check_eq("rst_err", {31'b0, bus.err}, 32'd0);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("rst_ndig", {28'b0, bus.ndig}, 32'd0);
    rst = 1'b0;

    // Mixed-case full-width value, ndig tracked per digit.
    s1 = "1A2b3C4d";
    for (int i = 0; i < s1.len(); i++) begin
      send_byte(s1[i]);
      @(negedge clk);
      check_eq("ndig_accum", {28'b0, bus.ndig}, 32'(i + 1));
    end
    check_eq("busy_accum", {31'b0, bus.busy}, 32'd1);
    push_exp(1'b0, 32'h1A2B3C4D);
    send_byte(8'h0D);
    @(negedge clk);
    check_eq("ndig_after_commit", {28'b0, bus.ndig}, 32'd0);
    check_eq("busy_after_commit", {31'b0, bus.busy}, 32'd0);

    // CR LF commits once.
    send_str("7F");
    push_exp(1'b0, 32'h0000007F);
    send_byte(8'h0D);
    send_byte(8'h0A);
    @(negedge clk);
    check_eq("value_7f", bus.value, 32'h0000007F);

    // Nine digits overflow MAX_DIGITS=8.
    send_str("12345678");
    @(negedge clk);
    check_eq("ndig_max", {28'b0, bus.ndig}, 32'd8);
    send_byte("9");
    @(negedge clk);
    check_eq("busy_discard", {31'b0, bus.busy}, 32'd1);
    push_exp(1'b1, 32'd0);
    send_byte(8'h0D);
    @(negedge clk);
    check_eq("value_kept_overflow", bus.value, 32'h0000007F);
    check_eq("ndig_after_err", {28'b0, bus.ndig}, 32'd0);

    // Invalid character then a good line.
    send_str("12G4");
    push_exp(1'b1, 32'd0);
    send_byte(8'h0A);
    send_byte("5");
    push_exp(1'b0, 32'h00000005);
    send_byte(8'h0D);
    last_val = 32'h00000005;

    // Backspace behaviour depends on build option.
    send_str("ABC");
    send_byte(8'h08);
`ifdef HEX_RX_BACKSPACE_EN
    @(negedge clk);
    check_eq("ndig_bksp", {28'b0, bus.ndig}, 32'd2);
    send_byte("D");
    push_exp(1'b0, 32'h00000ABD);
    last_val = 32'h00000ABD;
`else
    send_byte("D");
    push_exp(1'b1, 32'd0);
`endif
    send_byte(8'h0D);
    @(negedge clk);
    check_eq("value_after_bksp", bus.value, last_val);

    // Reset in the middle of a line.
    send_str("DEAD");
    #3 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_value", bus.value, 32'd0);
    check_eq("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("midrst_ndig", {28'b0, bus.ndig}, 32'd0);
    rst = 1'b0;
    send_byte("1");
    push_exp(1'b0, 32'h00000001);
    send_byte(8'h0D);
    repeat (4) @(negedge clk);
    check_eq("final_value", bus.value, 32'h00000001);
    check_eq("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
